// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, tag encoding and source indices for the common data bus arbiter.
package cdb_arbiter_pkg;

   localparam int dataWidth = 32;
   localparam int tagWidth  = 6;
   localparam int numSrc    = 3;

   localparam logic [tagWidth-1:0] tagFree = '1;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSU = 2'd1;
   localparam logic [1:0] SRC_BRU = 2'd2;

   typedef struct packed {
      logic [tagWidth-1:0]  tag;
      logic [dataWidth-1:0] data;
   } cdb_entry_t;

   // Round-robin successor over the three sources.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == SRC_BRU) ? SRC_ALU : idx + 2'd1;
   endfunction

endpackage

// File: rtl/cdb_fifo2.sv
// Two-entry result queue in front of the CDB; push/pop arrive already qualified by the arbiter.
module cdb_fifo2
   import cdb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  cdb_entry_t wr_entry,
   output cdb_entry_t head,
   output logic       full,
   output logic       empty
);

   cdb_entry_t mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;

   // Pointers toggle to wrap modulo 2; a simultaneous push and pop leaves occupancy alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= wr_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of ALU/LSU/BRU results onto the common data bus.
// Define CDB_OUT_REG_EN to register the cdb_* outputs (one extra cycle of latency).
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic                 alu_valid,
   input  logic                 lsu_valid,
   input  logic                 bru_valid,
   input  logic [tagWidth-1:0]  alu_tag,
   input  logic [tagWidth-1:0]  lsu_tag,
   input  logic [tagWidth-1:0]  bru_tag,
   input  logic [dataWidth-1:0] alu_data,
   input  logic [dataWidth-1:0] lsu_data,
   input  logic [dataWidth-1:0] bru_data,
   output logic                 alu_ready,
   output logic                 lsu_ready,
   output logic                 bru_ready,
   output logic                 cdb_valid,
   output logic [tagWidth-1:0]  cdb_tag,
   output logic [dataWidth-1:0] cdb_data,
   output logic [1:0]           cdb_src
);

   logic [2:0] in_valid;
   logic [2:0] ready;
   logic [2:0] push;
   logic [2:0] store;
   logic [2:0] pop;
   logic [2:0] full;
   logic [2:0] empty;
   cdb_entry_t in_entry [3];
   cdb_entry_t head [3];
   logic [1:0] ptr;
   logic [1:0] scan_idx;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       advance;
   logic       do_flush;

   assign in_valid          = {bru_valid, lsu_valid, alu_valid};
   assign in_entry[SRC_ALU] = {alu_tag, alu_data};
   assign in_entry[SRC_LSU] = {lsu_tag, lsu_data};
   assign in_entry[SRC_BRU] = {bru_tag, bru_data};

   assign advance  = rdy && !flush;
   assign do_flush = rdy && flush;
   assign ready    = ~full;
   assign push     = in_valid & ready & {3{advance}};

   assign alu_ready = ready[SRC_ALU];
   assign lsu_ready = ready[SRC_LSU];
   assign bru_ready = ready[SRC_BRU];

   // A tagFree result still completes its handshake but is never queued.
   for (genvar i = 0; i < numSrc; i++) begin : g_fifo
      assign store[i] = push[i] && (in_entry[i].tag != tagFree);
      assign pop[i]   = advance && grant_valid && (grant_idx == 2'(i));

      cdb_fifo2 u_fifo (
         .clk      (clk),
         .rst      (rst),
         .flush    (do_flush),
         .push     (store[i]),
         .pop      (pop[i]),
         .wr_entry (in_entry[i]),
         .head     (head[i]),
         .full     (full[i]),
         .empty    (empty[i])
      );
   end

   // Scan the heads starting at ptr; the first non-empty one wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = SRC_ALU;
      scan_idx    = ptr;
      for (int k = 0; k < numSrc; k++) begin
         if (!grant_valid && !empty[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
         scan_idx = rr_next(scan_idx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= SRC_ALU;
      else if (do_flush)
         ptr <= SRC_ALU;
      else if (advance && grant_valid)
         ptr <= rr_next(grant_idx);
   end

`ifdef CDB_OUT_REG_EN
   // Registered broadcast: captures the head popped this cycle, holds while rdy is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || do_flush) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= tagFree;
         cdb_data  <= '0;
         cdb_src   <= SRC_ALU;
      end else if (advance) begin
         cdb_valid <= grant_valid;
         cdb_tag   <= grant_valid ? head[grant_idx].tag  : tagFree;
         cdb_data  <= grant_valid ? head[grant_idx].data : '0;
         cdb_src   <= grant_valid ? grant_idx : SRC_ALU;
      end
   end
`else
   always_comb begin
      cdb_valid = 1'b0;
      cdb_tag   = tagFree;
      cdb_data  = '0;
      cdb_src   = SRC_ALU;
      if (!rst && grant_valid) begin
         cdb_valid = 1'b1;
         cdb_tag   = head[grant_idx].tag;
         cdb_data  = head[grant_idx].data;
         cdb_src   = grant_idx;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue-level model.
`timescale 1ns/1ps
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

`ifdef CDB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                 clk;
   logic                 rst;
   logic                 rdy;
   logic                 flush;
   logic [2:0]           vin;
   logic [tagWidth-1:0]  tin [3];
   logic [dataWidth-1:0] din [3];
   logic                 alu_ready, lsu_ready, bru_ready;
   logic                 cdb_valid;
   logic [tagWidth-1:0]  cdb_tag;
   logic [dataWidth-1:0] cdb_data;
   logic [1:0]           cdb_src;

   int vectors;
   int miscompares;

   // Reference model: per-source lists with the oldest entry at index 0.
   int                   mcnt [3];
   logic [tagWidth-1:0]  mtag [3][2];
   logic [dataWidth-1:0] mdata [3][2];
   int                   mptr;
   logic                 rv;
   logic [tagWidth-1:0]  rt;
   logic [dataWidth-1:0] rd;
   logic [1:0]           rs;

   int                   sent;
   int                   got;
   bit                   saw_low;
   logic [tagWidth-1:0]  got_tags [3];

   cdb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .alu_valid (vin[0]),
      .lsu_valid (vin[1]),
      .bru_valid (vin[2]),
      .alu_tag   (tin[0]),
      .lsu_tag   (tin[1]),
      .bru_tag   (tin[2]),
      .alu_data  (din[0]),
      .lsu_data  (din[1]),
      .bru_data  (din[2]),
      .alu_ready (alu_ready),
      .lsu_ready (lsu_ready),
      .bru_ready (bru_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic void model_pick(output bit gv, output int gi);
      gv = 1'b0;
      gi = 0;
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (mptr + k) % 3;
         if (!gv && mcnt[s] > 0) begin
            gv = 1'b1;
            gi = s;
         end
      end
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) mcnt[s] = 0;
      mptr = 0;
      rv   = 1'b0;
      rt   = tagFree;
      rd   = '0;
      rs   = 2'd0;
   endtask

   task automatic model_clock();
      bit gv;
      int gi;
      bit acc [3];
      if (!rdy) return;
      if (flush) begin
         model_reset();
         return;
      end
      model_pick(gv, gi);
      for (int s = 0; s < 3; s++) acc[s] = vin[s] && (mcnt[s] < 2);
      rv = gv;
      rt = gv ? mtag[gi][0] : tagFree;
      rd = gv ? mdata[gi][0] : '0;
      rs = gv ? 2'(gi) : 2'd0;
      if (gv) begin
         mtag[gi][0]  = mtag[gi][1];
         mdata[gi][0] = mdata[gi][1];
         mcnt[gi]--;
         mptr = (gi + 1) % 3;
      end
      for (int s = 0; s < 3; s++) begin
         if (acc[s] && tin[s] != tagFree) begin
            mtag[s][mcnt[s]]  = tin[s];
            mdata[s][mcnt[s]] = din[s];
            mcnt[s]++;
         end
      end
   endtask

   task automatic checkOutput();
      logic                 ev;
      logic [tagWidth-1:0]  et;
      logic [dataWidth-1:0] ed;
      logic [1:0]           es;
`ifdef CDB_OUT_REG_EN
      ev = rv;
      et = rt;
      ed = rd;
      es = rs;
`else
      bit gv;
      int gi;
      model_pick(gv, gi);
      ev = gv;
      et = gv ? mtag[gi][0] : tagFree;
      ed = gv ? mdata[gi][0] : '0;
      es = gv ? 2'(gi) : 2'd0;
`endif
      chk("cdb_valid", 64'(cdb_valid), 64'(ev));
      chk("cdb_tag",   64'(cdb_tag),   64'(et));
      chk("cdb_data",  64'(cdb_data),  64'(ed));
      chk("cdb_src",   64'(cdb_src),   64'(es));
      chk("alu_ready", 64'(alu_ready), 64'(mcnt[0] < 2));
      chk("lsu_ready", 64'(lsu_ready), 64'(mcnt[1] < 2));
      chk("bru_ready", 64'(bru_ready), 64'(mcnt[2] < 2));
   endtask

   task automatic setInputs(input logic [2:0] v, input logic r, input logic f);
      vin   = v;
      rdy   = r;
      flush = f;
      for (int i = 0; i < 3; i++) begin
         tin[i] = tagWidth'($urandom_range(0, int'(tagFree) - 1));
         din[i] = $urandom;
      end
   endtask

   // One clock: check at the current state, then advance DUT and model together.
   task automatic applyStimulus();
      #1;
      checkOutput();
      @(posedge clk);
      if (!rst) model_clock();
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      setInputs(3'b000, 1'b1, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      checkOutput();
      chk("reset_valid", 64'(cdb_valid), 64'(1'b0));
      chk("reset_tag",   64'(cdb_tag),   64'(tagFree));
      rst = 1'b0;
      @(negedge clk);

      // Single ALU result tag 3 / data 0x11.
      setInputs(3'b001, 1'b1, 1'b0);
      tin[0] = 6'd3;
      din[0] = 32'h11;
      applyStimulus();
      setInputs(3'b000, 1'b1, 1'b0);
`ifdef CDB_OUT_REG_EN
      applyStimulus();
      setInputs(3'b000, 1'b1, 1'b0);
`endif
      #1;
      chk("single_valid", 64'(cdb_valid), 64'(1'b1));
      chk("single_tag",   64'(cdb_tag),   64'(6'd3));
      chk("single_data",  64'(cdb_data),  64'(32'h11));
      chk("single_src",   64'(cdb_src),   64'(SRC_ALU));
      applyStimulus();

      // Fairness: all sources saturated from ptr=0 rotate ALU, LSU, BRU.
      setInputs(3'b000, 1'b1, 1'b1);
      applyStimulus();
      for (int k = 0; k < 6 + LAT; k++) begin
         setInputs(3'b111, 1'b1, 1'b0);
         #1;
         if (k >= LAT) begin
            chk("fair_valid", 64'(cdb_valid), 64'(1'b1));
            chk("fair_src",   64'(cdb_src),   64'((k - LAT) % 3));
         end
         applyStimulus();
      end

      // Backpressure: LSU offers three results while ALU and BRU keep queues busy.
      setInputs(3'b000, 1'b1, 1'b1);
      applyStimulus();
      sent    = 0;
      got     = 0;
      saw_low = 1'b0;
      for (int c = 0; c < 40 && got < 3; c++) begin
         setInputs((sent < 3) ? 3'b111 : 3'b000, 1'b1, 1'b0);
         tin[1] = tagWidth'(10 + sent);
         din[1] = 32'h100 + 32'(sent);
         #1;
         if (!lsu_ready) saw_low = 1'b1;
         if (cdb_valid && cdb_src == SRC_LSU) begin
            got_tags[got] = cdb_tag;
            got++;
         end
         if (lsu_ready && vin[1]) sent++;
         applyStimulus();
      end
      chk("lsu_bp_seen", 64'(saw_low), 64'(1'b1));
      chk("lsu_count",   64'(got),     64'(3));
      for (int i = 0; i < 3; i++)
         chk("lsu_order", 64'(got_tags[i]), 64'(10 + i));

      // Flush in the same cycle as a BRU push.
      setInputs(3'b000, 1'b1, 1'b1);
      applyStimulus();
      setInputs(3'b011, 1'b1, 1'b0);
      applyStimulus();
      setInputs(3'b100, 1'b1, 1'b1);
      applyStimulus();
      for (int k = 0; k < 2; k++) begin
         setInputs(3'b000, 1'b1, 1'b0);
         #1;
         chk("flush_valid", 64'(cdb_valid), 64'(1'b0));
         chk("flush_ready", 64'({alu_ready, lsu_ready, bru_ready}), 64'(3'b111));
         applyStimulus();
      end

      // Freeze for three cycles with entries queued, then resume.
      repeat (2) begin
         setInputs(3'b111, 1'b1, 1'b0);
         applyStimulus();
      end
      repeat (3) begin
         setInputs(3'($urandom), 1'b0, 1'($urandom));
         applyStimulus();
      end
      repeat (5) begin
         setInputs(3'b000, 1'b1, 1'b0);
         applyStimulus();
      end

      // A tagFree result is swallowed.
      setInputs(3'b000, 1'b1, 1'b1);
      applyStimulus();
      setInputs(3'b001, 1'b1, 1'b0);
      tin[0] = tagFree;
      din[0] = 32'hFF;
      applyStimulus();
      repeat (3) begin
         setInputs(3'b000, 1'b1, 1'b0);
         #1;
         chk("tagfree_hidden", 64'(cdb_valid), 64'(1'b0));
         applyStimulus();
      end

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         setInputs(3'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 7) == 0) tin[i] = tagFree;
         applyStimulus();
      end

      // Asynchronous reset between clock edges with traffic queued.
      repeat (2) begin
         setInputs(3'b111, 1'b1, 1'b0);
         applyStimulus();
      end
      setInputs(3'b111, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_valid", 64'(cdb_valid), 64'(1'b0));
      chk("async_rst_tag",   64'(cdb_tag),   64'(tagFree));
      checkOutput();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         setInputs(3'($urandom), 1'b1, 1'b0);
         applyStimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rdy  input  1  global ready; low = freeze all state.
REQ-004 flush  input  1  mispredict clear from ROB, synchronous.
REQ-005 alu_valid, lsu_valid, bru_valid  input  1 each  requester result valid.
REQ-006 alu_tag, lsu_tag, bru_tag  input  tagWidth each  ROB tag of result.
REQ-007 alu_data, lsu_data, bru_data  input  dataWidth each  result value.
REQ-008 alu_ready, lsu_ready, bru_ready  output  1 each  source FIFO not full.
REQ-009 cdb_valid  output  1  broadcast valid to regfile/ROB/RS.
REQ-010 cdb_tag  output  tagWidth  broadcast tag.
REQ-011 cdb_data  output  dataWidth  broadcast data.
REQ-012 cdb_src  output  2  granted source: 0 = ALU, 1 = LSU, 2 = BRU.

Function
REQ-013 Each source SHALL own a 2-entry FIFO; push = valid && ready && rdy && !flush.
REQ-014 x_ready SHALL equal FIFO not full, registered state only; no same-cycle pop passthrough.
REQ-015 A push with tag == tagFree SHALL be accepted and discarded, never broadcast.
REQ-016 An entry pushed in cycle N SHALL be eligible for arbitration from cycle N+1; no cut-through.
REQ-017 Arbitration SHALL be round-robin over non-empty FIFO heads, starting from pointer ptr (0..2).
REQ-018 At most one head SHALL be popped per cycle, and only when rdy=1 and flush=0.
REQ-019 After a grant to source i, ptr SHALL become (i+1) mod 3; with no grant, ptr SHALL hold.
REQ-020 With no eligible head, cdb_valid SHALL be 0, with cdb_tag = tagFree and cdb_data = 0.
REQ-021 rdy=0 SHALL block all pushes, pops and ptr updates; registered outputs SHALL hold.
REQ-022 flush=1 (with rdy=1) SHALL empty all FIFOs, set ptr=0 and clear cdb_valid next cycle.
REQ-023 flush SHALL win over a same-cycle push or pop.
REQ-024 Simultaneous push and pop on the same FIFO SHALL keep its occupancy unchanged.
REQ-025 FIFO read/write pointers SHALL wrap modulo 2.
REQ-026 No starvation: each non-empty source SHALL be granted within 3 rdy-high, flush-free cycles.

Reset
REQ-027 On rst: FIFOs empty, ptr=0, cdb_valid=0, cdb_tag=tagFree, cdb_data=0, cdb_src=0, all x_ready=1.
REQ-028 rst SHALL override rdy and flush, and SHALL take effect mid-operation without waiting for an edge.

Configuration
REQ-029 Macro CDB_OUT_REG_EN defined: cdb_* outputs SHALL be registered; push at N is broadcast at N+2 at the earliest.
REQ-030 Macro CDB_OUT_REG_EN undefined: cdb_* outputs SHALL be combinational from the granted head; push at N is broadcast at N+1; rst forces idle values.

Structure
REQ-031 dataWidth, tagWidth, tagFree and source-index constants (SRC_ALU=0, SRC_LSU=1, SRC_BRU=2) SHALL come from the shared defines package.
REQ-032 The 2-entry FIFO SHALL be sub-module cdb_fifo2, instantiated three times.

Verification
REQ-033 Single source: ALU pushes tag=3, data=0x11 at cycle 0 -> cdb_valid=1, cdb_tag=3, cdb_data=0x11, cdb_src=0 at cycle 2 (REG_EN) or cycle 1 (no REG_EN).
REQ-034 Fairness: all three FIFOs full, ptr=0 -> grant order ALU, LSU, BRU, ALU, LSU, BRU in consecutive cycles.
REQ-035 Backpressure: LSU pushes 3 results back-to-back while the ALU and BRU FIFOs hold entries -> lsu_ready=0 after 2 entries; the third result is held and accepted once space frees; no loss, FIFO order kept.
REQ-036 Flush: 2 entries queued, flush=1 in the same cycle as a BRU push -> all FIFOs empty, ptr=0, cdb_valid=0 next cycle, BRU entry dropped.
REQ-037 rdy=0 for 3 cycles with entries queued -> no pops, ptr unchanged, outputs held; on rdy=1 resume from the same ptr.
REQ-038 tagFree push (tag=tagFree, data=0xFF) -> never appears on the CDB; async rst mid-stream -> outputs idle immediately.
